// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed image over UART 8N1, writes it byte by byte
// into the boot ROM, verifies length and checksum, then releases the CPU reset.
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT   = 434,
  parameter int          MEM_BYTES      = 9216,
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int          TIMEOUT_CYCLES = 50000000
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        rx,
  output logic [31:0] address,
  output logic [7:0]  wr_data,
  output logic        store,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_reset_n
);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] MAXL = 17'(MEM_BYTES);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {WAIT_SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE} st_t;

  rx_t         rs, rs_n;
  st_t         state, state_n;
  logic        rx_m, rx_s, rx_q;
  logic [15:0] rcnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic        byte_valid, frame_err;
  logic        tick, half;
  logic [7:0]  len_lo, sum;
  logic [15:0] len, idx, len_n;
  logic [31:0] tcnt;
  logic        sync, st, ok, fail;

  assign tick  = rcnt == FULL;
  assign half  = rcnt == HALF;
  assign len_n = {shreg, len_lo};

  always_comb begin
    rs_n = rs;
    case (rs)
      R_IDLE:  if (rx_q && !rx_s) rs_n = R_START;
      R_START: if (half) rs_n = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (tick && bitn == 3'd7) rs_n = R_STOP;
      default: if (tick) rs_n = R_IDLE;
    endcase
  end

  // shreg keeps the received byte stable while byte_valid is high
  always_ff @(posedge m_clock or negedge p_reset)
    if (!p_reset) begin
      {rx_m, rx_s, rx_q} <= 3'b111;
      rs                 <= R_IDLE;
      rcnt               <= '0;
      bitn               <= '0;
      shreg              <= '0;
      byte_valid         <= 1'b0;
      frame_err          <= 1'b0;
    end else begin
      {rx_m, rx_s, rx_q} <= {rx, rx_m, rx_s};
      rs                 <= rs_n;
      rcnt               <= (rs_n != rs || rs == R_IDLE || tick) ? '0 : rcnt + 16'd1;
      if (rs == R_DATA && tick) begin
        bitn  <= bitn + 3'd1;
        shreg <= {rx_s, shreg[7:1]};
      end
      byte_valid <= rs == R_STOP && tick && rx_s;
      frame_err  <= rs == R_STOP && tick && !rx_s;
    end

  always_comb begin
    state_n = state;
    sync    = 1'b0;
    st      = 1'b0;
    ok      = 1'b0;
    fail    = 1'b0;
    if (byte_valid)
      case (state)
        WAIT_SYNC: if (shreg == 8'hA5) begin sync = 1'b1; state_n = LEN_LO; end
        LEN_LO:    state_n = LEN_HI;
        LEN_HI:    if (len_n == 16'd0 || {1'b0, len_n} > MAXL) fail = 1'b1; else state_n = DATA;
        DATA:      begin st = 1'b1; if (idx + 16'd1 == len) state_n = CSUM; end
        CSUM:      if (shreg == sum) begin ok = 1'b1; state_n = DONE; end else fail = 1'b1;
        default:   ;
      endcase
    else if (state != WAIT_SYNC && state != DONE && (frame_err || tcnt == TLIM))
      fail = 1'b1;
    if (fail) state_n = WAIT_SYNC;
  end

  always_ff @(posedge m_clock or negedge p_reset)
    if (!p_reset) begin
      state       <= WAIT_SYNC;
      len_lo      <= '0;
      len         <= '0;
      idx         <= '0;
      sum         <= '0;
      tcnt        <= '0;
      address     <= '0;
      wr_data     <= '0;
      store       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      state <= state_n;
      store <= st;
      if (byte_valid && state == LEN_LO) len_lo <= shreg;
      if (byte_valid && state == LEN_HI) len <= len_n;
      idx <= sync ? '0 : st ? idx + 16'd1 : idx;
      sum <= sync ? '0 : st ? sum + shreg : sum;
      if (st) begin
        address <= BASE_ADDR + {16'd0, idx};
        wr_data <= shreg;
      end
      tcnt        <= (byte_valid || state == WAIT_SYNC || state == DONE) ? '0 : tcnt + 32'd1;
      busy        <= sync | (busy & ~fail & ~ok);
      error       <= ~sync & (error | fail);
      done        <= done | ok;
      cpu_reset_n <= cpu_reset_n | ok;
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames over a fast UART with hand-computed expectations.
module tb_uart_boot_loader;
  localparam int CPB = 4;
  localparam int TO  = 100;

  logic        m_clock = 1'b0;
  logic        p_reset;
  logic        rx;
  logic [31:0] address;
  logic [7:0]  wr_data;
  logic        store, busy, done, error, cpu_reset_n;
  int          total = 0;
  int          bad = 0;
  logic [31:0] sa[$];
  logic [7:0]  sd[$];

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .MEM_BYTES(9216), .BASE_ADDR(32'd0), .TIMEOUT_CYCLES(TO)) dut (
    .m_clock(m_clock), .p_reset(p_reset), .rx(rx), .address(address), .wr_data(wr_data),
    .store(store), .busy(busy), .done(done), .error(error), .cpu_reset_n(cpu_reset_n)
  );

  always #5 m_clock = ~m_clock;

  always @(negedge m_clock)
    if (store === 1'b1) begin
      sa.push_back(address);
      sd.push_back(wr_data);
    end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge m_clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge m_clock);
    end
    rx = stop;
    repeat (CPB) @(negedge m_clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge m_clock);
  endtask

  task automatic send_seq(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset;
    p_reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge m_clock);
    p_reset = 1'b1;
    repeat (3) @(negedge m_clock);
    sa.delete();
    sd.delete();
  endtask

  task automatic test_reset;
    do_reset();
    repeat (1000) @(negedge m_clock);
    total++; if (address !== 32'd0) begin bad++; $display("FAIL reset_address got %h want 0", address); end
    total++; if (wr_data !== 8'd0) begin bad++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    total++; if (sa.size() !== 0) begin bad++; $display("FAIL reset_stores got %0d want 0", sa.size()); end
    total++; if ({busy, done, error, cpu_reset_n, store} !== 5'b0) begin bad++; $display("FAIL reset_flags got %b want 00000", {busy, done, error, cpu_reset_n, store}); end
  endtask

  task automatic test_load;
    do_reset();
    send_seq({8'h00, 8'h5A, 8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33}, 8);
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL load_pre_csum busy/done got %b want 10", {busy, done}); end
    send_byte(8'h66, 1'b1);
    total++; if ({done, cpu_reset_n, error, busy} !== 4'b1100) begin bad++; $display("FAIL load_done flags got %b want 1100", {done, cpu_reset_n, error, busy}); end
    total++; if (sa.size() !== 3) begin bad++; $display("FAIL load_store_count got %0d want 3", sa.size()); end
    if (sa.size() == 3) begin
      total++; if ({sa[0], sa[1], sa[2]} !== {32'd0, 32'd1, 32'd2}) begin bad++; $display("FAIL load_addresses got %h %h %h want 0 1 2", sa[0], sa[1], sa[2]); end
      total++; if ({sd[0], sd[1], sd[2]} !== 24'h112233) begin bad++; $display("FAIL load_data got %h %h %h want 11 22 33", sd[0], sd[1], sd[2]); end
    end
    send_seq({8'hA5, 8'h01, 8'h00, 8'h44, 8'h44}, 5);
    total++; if (sa.size() !== 3) begin bad++; $display("FAIL load_after_done stores got %0d want 3", sa.size()); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL load_done_sticky got %b want 1", done); end
  endtask

  task automatic test_bad_csum;
    do_reset();
    send_seq({8'hA5, 8'h01, 8'h00, 8'h7F, 8'h00}, 5);
    total++; if (sa.size() !== 1) begin bad++; $display("FAIL csum_store_count got %0d want 1", sa.size()); end
    if (sa.size() == 1) begin
      total++; if ({sa[0], sd[0]} !== {32'd0, 8'h7F}) begin bad++; $display("FAIL csum_store got %h/%h want 0/7f", sa[0], sd[0]); end
    end
    total++; if ({error, done, busy} !== 3'b100) begin bad++; $display("FAIL csum_err flags got %b want 100", {error, done, busy}); end
    send_byte(8'hA5, 1'b1);
    total++; if ({error, busy} !== 2'b01) begin bad++; $display("FAIL csum_sync_clears error/busy got %b want 01", {error, busy}); end
    send_seq({8'h01, 8'h00, 8'h7F, 8'h7F}, 4);
    total++; if ({done, error, sa.size()} !== {2'b10, 32'd2}) begin bad++; $display("FAIL csum_retry done/error/stores got %b%b/%0d want 10/2", done, error, sa.size()); end
  endtask

  task automatic test_bad_len;
    do_reset();
    send_seq({8'hA5, 8'h00, 8'h00}, 3);
    total++; if ({error, busy, sa.size()} !== {2'b10, 32'd0}) begin bad++; $display("FAIL len_zero error/busy/stores got %b%b/%0d want 10/0", error, busy, sa.size()); end
    send_byte(8'hA5, 1'b1);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL len_sync_clears got %b want 0", error); end
    send_seq({8'h01, 8'h24}, 2);
    total++; if ({error, busy, sa.size()} !== {2'b10, 32'd0}) begin bad++; $display("FAIL len_9217 error/busy/stores got %b%b/%0d want 10/0", error, busy, sa.size()); end
  endtask

  task automatic test_framing;
    do_reset();
    send_seq({8'hA5, 8'h03, 8'h00, 8'h11}, 4);
    send_byte(8'h22, 1'b0);
    total++; if ({error, busy, sa.size()} !== {2'b10, 32'd1}) begin bad++; $display("FAIL frame_err error/busy/stores got %b%b/%0d want 10/1", error, busy, sa.size()); end
    send_seq({8'hA5, 8'h01, 8'h00, 8'h55, 8'h55}, 5);
    total++; if ({done, sa.size()} !== {1'b1, 32'd2}) begin bad++; $display("FAIL frame_resync done/stores got %b/%0d want 1/2", done, sa.size()); end
    if (sa.size() == 2) begin
      total++; if ({sa[1], sd[1]} !== {32'd0, 8'h55}) begin bad++; $display("FAIL frame_resync_store got %h/%h want 0/55", sa[1], sd[1]); end
    end
  endtask

  task automatic test_timeout;
    do_reset();
    send_seq({8'hA5, 8'h05, 8'h00}, 3);
    repeat (60) @(negedge m_clock);
    total++; if ({error, busy} !== 2'b01) begin bad++; $display("FAIL timeout_early error/busy got %b want 01", {error, busy}); end
    repeat (50) @(negedge m_clock);
    total++; if ({error, busy} !== 2'b10) begin bad++; $display("FAIL timeout_fired error/busy got %b want 10", {error, busy}); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    send_seq({8'hA5, 8'h03, 8'h00, 8'h11}, 4);
    rx = 1'b0;
    repeat (CPB) @(negedge m_clock);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge m_clock);
    end
    total++; if ({busy, sa.size()} !== {1'b1, 32'd1}) begin bad++; $display("FAIL mid_before busy/stores got %b/%0d want 1/1", busy, sa.size()); end
    #2 p_reset = 1'b0;
    #1;
    total++; if ({address, wr_data, store, busy, done, error, cpu_reset_n} !== 45'd0) begin bad++; $display("FAIL mid_reset_outputs got %h %h %b%b%b%b%b want all 0", address, wr_data, store, busy, done, error, cpu_reset_n); end
    rx = 1'b1;
    repeat (5) @(negedge m_clock);
    p_reset = 1'b1;
    repeat (3) @(negedge m_clock);
    sa.delete();
    sd.delete();
    send_seq({8'hA5, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h31}, 7);
    total++; if ({done, cpu_reset_n, error, sa.size()} !== {3'b110, 32'd3}) begin bad++; $display("FAIL mid_reload flags/stores got %b%b%b/%0d want 110/3", done, cpu_reset_n, error, sa.size()); end
    if (sa.size() == 3) begin
      total++; if ({sa[0], sa[1], sa[2], sd[0], sd[1], sd[2]} !== {32'd0, 32'd1, 32'd2, 24'hAABBCC}) begin bad++; $display("FAIL mid_reload_stores got %h %h %h / %h %h %h want 0 1 2 / aa bb cc", sa[0], sa[1], sa[2], sd[0], sd[1], sd[2]); end
    end
  endtask

  initial begin
    p_reset = 1'b0;
    rx = 1'b1;
    @(negedge m_clock);
    test_reset();
    test_load();
    test_bad_csum();
    test_bad_len();
    test_framing();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
